// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control encodings used by the decode stage and the execute-stage ALU.
// Holds opcodes, ALUOp / ALUControl / ResultSrc / ImmSrc codes and the ID/EX record layout.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // Code 4 is deliberately unused so the ALU can treat it as reserved.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       aluSrc;
    logic [1:0] immSrc;
    logic [2:0] aluControl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       valid;
    logic       illegal;
  } idex_t;

  localparam ctrl_t CTRL_BUBBLE = '0;
  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to the 3-bit ALUControl code.
// Flags funct3 values the ALU does not implement.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  aluop_e     i_aluOp,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_f7b5,
  output logic [2:0] o_aluControl,
  output logic       o_illegal
);

  // Only R-type (op5=1) can request SUB through funct7; addi with bit 30 set stays ADD.
  always_comb begin
    o_aluControl = ALU_ADD;
    o_illegal    = 1'b0;
    case (i_aluOp)
      ALUOP_ADD: o_aluControl = ALU_ADD;
      ALUOP_SUB: o_aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_aluControl = (i_op5 && i_f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_aluControl = ALU_SLT;
          3'b110:  o_aluControl = ALU_OR;
          3'b111:  o_aluControl = ALU_AND;
          default: o_illegal    = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID stage control decode and ID/EX pipeline register for the RV32I subset.
// Priority at each edge: reset > flush > stall > load.
module id_ex_ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ALUSrcE,
  output logic [1:0]  ImmSrcE,
  output logic [2:0]  ALUControlE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        ValidE,
  output logic        IllegalE
);

  ctrl_t      w_mainCtrl;
  aluop_e     w_aluOp;
  logic       w_opIllegal;
  logic [2:0] w_aluControl;
  logic       w_aluIllegal;
  logic       w_illegal;
  idex_t      w_next;
  idex_t      r_idex;
  logic       w_unusedBits;

  assign w_unusedBits = ^{InstrD[31], InstrD[29:25]};

  always_comb begin
    w_mainCtrl  = CTRL_BUBBLE;
    w_aluOp     = ALUOP_ADD;
    w_opIllegal = 1'b0;
    case (InstrD[6:0])
      OP_LOAD: begin
        w_mainCtrl.regWrite  = 1'b1;
        w_mainCtrl.immSrc    = IMM_I;
        w_mainCtrl.aluSrc    = 1'b1;
        w_mainCtrl.resultSrc = RES_MEM;
      end
      OP_STORE: begin
        w_mainCtrl.memWrite = 1'b1;
        w_mainCtrl.immSrc   = IMM_S;
        w_mainCtrl.aluSrc   = 1'b1;
      end
      OP_RTYPE: begin
        w_mainCtrl.regWrite  = 1'b1;
        w_mainCtrl.resultSrc = RES_ALU;
        w_aluOp              = ALUOP_FUNCT;
      end
      OP_IALU: begin
        w_mainCtrl.regWrite = 1'b1;
        w_mainCtrl.immSrc   = IMM_I;
        w_mainCtrl.aluSrc   = 1'b1;
        w_aluOp             = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        w_mainCtrl.branch = 1'b1;
        w_mainCtrl.immSrc = IMM_B;
        w_aluOp           = ALUOP_SUB;
        w_opIllegal       = (InstrD[14:12] != 3'b000);
      end
      OP_JAL: begin
        w_mainCtrl.regWrite  = 1'b1;
        w_mainCtrl.immSrc    = IMM_J;
        w_mainCtrl.resultSrc = RES_PC4;
        w_mainCtrl.jump      = 1'b1;
      end
      default: w_opIllegal = 1'b1;
    endcase
  end

  alu_decoder u_aluDecoder (
    .i_aluOp      (w_aluOp),
    .i_funct3     (InstrD[14:12]),
    .i_op5        (InstrD[5]),
    .i_f7b5       (InstrD[30]),
    .o_aluControl (w_aluControl),
    .o_illegal    (w_aluIllegal)
  );

  assign w_illegal = w_opIllegal | w_aluIllegal;

  // A trapped illegal keeps its register fields so the handler can report them.
  always_comb begin
    w_next = IDEX_BUBBLE;
    if (ValidD) begin
      if (w_illegal) begin
        if (ILLEGAL_TRAP) begin
          w_next.rs1     = InstrD[19:15];
          w_next.rs2     = InstrD[24:20];
          w_next.rd      = InstrD[11:7];
          w_next.valid   = 1'b1;
          w_next.illegal = 1'b1;
        end
      end else begin
        w_next.ctrl            = w_mainCtrl;
        w_next.ctrl.aluControl = w_aluControl;
        w_next.rs1             = InstrD[19:15];
        w_next.rs2             = InstrD[24:20];
        w_next.rd              = InstrD[11:7];
        w_next.valid           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex <= IDEX_BUBBLE;
    end else if (FlushE) begin
      r_idex <= IDEX_BUBBLE;
    end else if (!StallE) begin
      r_idex <= w_next;
    end
  end

  assign RegWriteE   = r_idex.ctrl.regWrite;
  assign ResultSrcE  = r_idex.ctrl.resultSrc;
  assign MemWriteE   = r_idex.ctrl.memWrite;
  assign BranchE     = r_idex.ctrl.branch;
  assign JumpE       = r_idex.ctrl.jump;
  assign ALUSrcE     = r_idex.ctrl.aluSrc;
  assign ImmSrcE     = r_idex.ctrl.immSrc;
  assign ALUControlE = r_idex.ctrl.aluControl;
  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;
  assign RdE         = r_idex.rd;
  assign ValidE      = r_idex.valid;
  assign IllegalE    = r_idex.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Testbench for id_ex_ctrl_stage: directed vector table, stall/flush/reset sequences, random traffic.
// Two instances share inputs, one trapping illegal encodings and one turning them into bubbles.
module tb_id_ex_ctrl_stage;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       aluSrc;
    logic [1:0] immSrc;
    logic [2:0] aluCtrl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       valid;
    logic       illegal;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    obs_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        StallE;
  logic        FlushE;

  logic       regWrite1, memWrite1, branch1, jump1, aluSrc1, valid1, illegal1;
  logic [1:0] resultSrc1, immSrc1;
  logic [2:0] aluCtrl1;
  logic [4:0] rs11, rs21, rd1;
  logic       regWrite0, memWrite0, branch0, jump0, aluSrc0, valid0, illegal0;
  logic [1:0] resultSrc0, immSrc0;
  logic [2:0] aluCtrl0;
  logic [4:0] rs10, rs20, rd0;

  obs_t obs1, obs0, exp1, exp0;
  vec_t vecs[$];
  int   checks;
  int   errors;

  id_ex_ctrl_stage #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .RegWriteE(regWrite1), .ResultSrcE(resultSrc1), .MemWriteE(memWrite1), .BranchE(branch1),
    .JumpE(jump1), .ALUSrcE(aluSrc1), .ImmSrcE(immSrc1), .ALUControlE(aluCtrl1),
    .Rs1E(rs11), .Rs2E(rs21), .RdE(rd1), .ValidE(valid1), .IllegalE(illegal1)
  );

  id_ex_ctrl_stage #(.ILLEGAL_TRAP(1'b0)) dutNoTrap (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .RegWriteE(regWrite0), .ResultSrcE(resultSrc0), .MemWriteE(memWrite0), .BranchE(branch0),
    .JumpE(jump0), .ALUSrcE(aluSrc0), .ImmSrcE(immSrc0), .ALUControlE(aluCtrl0),
    .Rs1E(rs10), .Rs2E(rs20), .RdE(rd0), .ValidE(valid0), .IllegalE(illegal0)
  );

  assign obs1 = {regWrite1, resultSrc1, memWrite1, branch1, jump1, aluSrc1, immSrc1, aluCtrl1,
                 rs11, rs21, rd1, valid1, illegal1};
  assign obs0 = {regWrite0, resultSrc0, memWrite0, branch0, jump0, aluSrc0, immSrc0, aluCtrl0,
                 rs10, rs20, rd0, valid0, illegal0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obsOf(logic rw, logic [1:0] rs, logic mw, logic br, logic j,
                                 logic as, logic [1:0] imm, logic [2:0] alu,
                                 logic [4:0] r1, logic [4:0] r2, logic [4:0] rdv,
                                 logic v, logic ill);
    obs_t o;
    o = '{rw, rs, mw, br, j, as, imm, alu, r1, r2, rdv, v, ill};
    return o;
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic obs_t model(logic [31:0] ins, logic v, bit trap);
    obs_t o;
    bit bad;
    logic [6:0] op;
    logic [2:0] f3;
    o = '0;
    bad = 0;
    op = ins[6:0];
    f3 = ins[14:12];
    if (!v) return o;
    case (op)
      7'h03: begin o.regWrite = 1; o.resultSrc = 2'b01; o.aluSrc = 1; end
      7'h23: begin o.memWrite = 1; o.immSrc = 2'b01; o.aluSrc = 1; end
      7'h33, 7'h13: begin
        o.regWrite = 1;
        o.aluSrc = (op == 7'h13);
        if (f3 == 3'd0)      o.aluCtrl = (op == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
        else if (f3 == 3'd2) o.aluCtrl = 3'd5;
        else if (f3 == 3'd6) o.aluCtrl = 3'd3;
        else if (f3 == 3'd7) o.aluCtrl = 3'd2;
        else bad = 1;
      end
      7'h63: begin o.branch = 1; o.immSrc = 2'b10; o.aluCtrl = 3'd1; bad = (f3 != 3'd0); end
      7'h6F: begin o.regWrite = 1; o.immSrc = 2'b11; o.resultSrc = 2'b10; o.jump = 1; end
      default: bad = 1;
    endcase
    if (bad) begin
      o = '0;
      if (!trap) return o;
      o.illegal = 1;
    end
    o.rs1 = ins[19:15];
    o.rs2 = ins[24:20];
    o.rd = ins[11:7];
    o.valid = 1;
    return o;
  endfunction

  task automatic addVec(input string n, input logic [31:0] ins, input logic v, input obs_t e);
    vec_t x;
    x.name = n;
    x.instr = ins;
    x.valid = v;
    x.exp = e;
    vecs.push_back(x);
  endtask

  task automatic checkOutput(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    @(negedge clk);
    InstrD = ins;
    ValidD = v;
    StallE = st;
    FlushE = fl;
    @(posedge clk);
    if (fl) begin
      exp1 = '0;
      exp0 = '0;
    end else if (!st) begin
      exp1 = model(ins, v, 1'b1);
      exp0 = model(ins, v, 1'b0);
    end
    #1;
  endtask

  initial begin
    logic [6:0] opPick[7];
    logic [31:0] rIns;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    InstrD = '0;
    ValidD = 1'b0;
    StallE = 1'b0;
    FlushE = 1'b0;
    exp1 = '0;
    exp0 = '0;

    addVec("add",      32'h002081B3, 1, obsOf(1,0,0,0,0,0,0,0, 1, 2,3,1,0));
    addVec("sub",      32'h402081B3, 1, obsOf(1,0,0,0,0,0,0,1, 1, 2,3,1,0));
    addVec("addi_neg", 32'hFFF00293, 1, obsOf(1,0,0,0,0,1,0,0, 0,31,5,1,0));
    addVec("beq",      32'h00208463, 1, obsOf(0,0,0,1,0,0,2,1, 1, 2,8,1,0));
    addVec("lw",       32'h0000A183, 1, obsOf(1,1,0,0,0,1,0,0, 1, 0,3,1,0));
    addVec("sw",       32'h0020A223, 1, obsOf(0,0,1,0,0,1,1,0, 1, 2,4,1,0));
    addVec("jal",      32'h008000EF, 1, obsOf(1,2,0,0,1,0,3,0, 0, 8,1,1,0));
    addVec("slt",      32'h0020A1B3, 1, obsOf(1,0,0,0,0,0,0,5, 1, 2,3,1,0));
    addVec("or",       32'h0020E1B3, 1, obsOf(1,0,0,0,0,0,0,3, 1, 2,3,1,0));
    addVec("and",      32'h0020F1B3, 1, obsOf(1,0,0,0,0,0,0,2, 1, 2,3,1,0));
    addVec("addi_b30", 32'h40008293, 1, obsOf(1,0,0,0,0,1,0,0, 1, 0,5,1,0));
    addVec("zero_ill", 32'h00000000, 1, obsOf(0,0,0,0,0,0,0,0, 0, 0,0,1,1));
    addVec("sll_ill",  32'h002091B3, 1, obsOf(0,0,0,0,0,0,0,0, 1, 2,3,1,1));
    addVec("bne_ill",  32'h00209463, 1, obsOf(0,0,0,0,0,0,0,0, 1, 2,8,1,1));
    addVec("invalid",  32'h002081B3, 0, obsOf(0,0,0,0,0,0,0,0, 0, 0,0,0,0));

    #12;
    checkOutput("reset_trap", obs1, '0);
    checkOutput("reset_notrap", obs0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].instr, vecs[i].valid, 1'b0, 1'b0);
      checkOutput({vecs[i].name, "_trap"}, obs1, vecs[i].exp);
      checkOutput({vecs[i].name, "_notrap"}, obs0, model(vecs[i].instr, vecs[i].valid, 1'b0));
    end
    checkOutput("zero_notrap_bubble", obs0, '0);

    // Stall holds the add while InstrD moves on; flush wins over stall.
    applyStimulus(32'h002081B3, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h402081B3, 1, 1, 0);
      checkOutput("stall_hold", obs1, vecs[0].exp);
    end
    applyStimulus(32'h402081B3, 1, 1, 1);
    checkOutput("flush_over_stall", obs1, '0);
    checkOutput("flush_notrap", obs0, '0);

    // Asynchronous reset in the middle of a cycle while the sub is held.
    applyStimulus(32'h402081B3, 1, 0, 0);
    checkOutput("sub_loaded", obs1, vecs[1].exp);
    applyStimulus(32'h002081B3, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_trap", obs1, '0);
    checkOutput("async_reset_notrap", obs0, '0);
    #2 rst_n = 1'b1;
    StallE = 1'b0;
    @(posedge clk);
    #1;
    exp1 = model(32'h002081B3, 1'b1, 1'b1);
    exp0 = model(32'h002081B3, 1'b1, 1'b0);
    checkOutput("post_reset_load", obs1, vecs[0].exp);
    checkOutput("post_reset_notrap", obs0, exp0);

    opPick = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
    for (int n = 0; n < 400; n++) begin
      int sel;
      rIns = $urandom;
      sel = $urandom_range(0, 6);
      if (sel < 6) rIns[6:0] = opPick[sel];
      else rIns[6:0] = 7'($urandom);
      applyStimulus(rIns, ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 9) == 0));
      checkOutput("random_trap", obs1, exp1);
      checkOutput("random_notrap", obs0, exp0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
- Producer end of the ALU control interface.
- Decodes the 32-bit RV32I instruction held in the IF/ID register into main-control signals and the 3-bit ALUControl code the execute-stage ALU consumes.
- Registers the decoded controls and the register-index fields into the ID/EX pipeline register.
- Supports hazard-unit stall and flush.

Parameters:
- ILLEGAL_TRAP, 1, 1: an unsupported encoding sets IllegalE; 0: it is silently converted to a bubble with IllegalE held 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- InstrD  in  32  instruction from IF/ID
- ValidD  in  1  InstrD holds a real instruction
- StallE  in  1  hold ID/EX contents
- FlushE  in  1  load a bubble into ID/EX
- RegWriteE  out  1  writes rd
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  out  1  store
- BranchE  out  1  beq
- JumpE  out  1  jal
- ALUSrcE  out  1  0 rs2, 1 immediate
- ImmSrcE  out  2  00 I, 01 S, 10 B, 11 J
- ALUControlE  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 5 SLT; 4 is never emitted
- Rs1E, Rs2E, RdE  out  5 each  InstrD[19:15], [24:20], [11:7]
- ValidE  out  1  ID/EX holds a real instruction
- IllegalE  out  1  unsupported encoding captured

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: all outputs 0, so ALUControlE = ADD and ValidE = 0 (a bubble). Reset is asserted immediately, regardless of clk.
- Latency: exactly 1 cycle. Decode is combinational from InstrD; the result is captured at the next rising edge.
- Update priority at each edge: reset > FlushE > StallE > load.
  - FlushE=1 loads a bubble even if StallE=1.
  - StallE=1 holds every output unchanged.
- Bubble: every control output 0, register fields 0, ValidE=0, IllegalE=0.
- Load with ValidD=0: load a bubble.
- Main decode on opcode InstrD[6:0]:
  - 0000011 lw: RegWrite=1, ImmSrc=00, ALUSrc=1, ResultSrc=01, ALUOp=00.
  - 0100011 sw: MemWrite=1, ImmSrc=01, ALUSrc=1, ALUOp=00.
  - 0110011 R-type: RegWrite=1, ALUSrc=0, ResultSrc=00, ALUOp=10.
  - 0010011 I-ALU: RegWrite=1, ImmSrc=00, ALUSrc=1, ALUOp=10.
  - 1100011 beq: Branch=1, ImmSrc=10, ALUSrc=0, ALUOp=01.
  - 1101111 jal: RegWrite=1, ImmSrc=11, ResultSrc=10, Jump=1, ALUOp=00.
  - Any other opcode: illegal.
  - Unlisted signals are 0.
- ALU decode, from ALUOp, funct3 = InstrD[14:12], op5 = InstrD[5], f7b5 = InstrD[30]:
  - ALUOp 00 -> ADD; ALUOp 01 -> SUB.
  - ALUOp 10, funct3 000 -> SUB if op5 & f7b5, else ADD. addi with a negative immediate is ADD.
  - ALUOp 10, funct3 010 -> SLT; 110 -> OR; 111 -> AND.
  - ALUOp 10, any other funct3: illegal.
- beq other than funct3 000: illegal.
- Illegal with ILLEGAL_TRAP=1:
  - Controls are loaded as a bubble.
  - ValidE=1, IllegalE=1; register fields are loaded.
- Illegal with ILLEGAL_TRAP=0: plain bubble.
- IllegalE and ValidE obey stall and flush exactly like the other outputs.

Decomposition:
- Shared package (rv_ctrl_pkg) holds:
  - opcode constants;
  - ALUOp codes;
  - ALUControl codes (ADD=0, SUB=1, AND=2, OR=3, SLT=5);
  - ResultSrc and ImmSrc codes;
  - the bubble constant.
- The execute-stage ALU imports the same ALUControl constants.
- One combinational sub-module, alu_decoder, maps (ALUOp, funct3, op5, f7b5) to (ALUControl, illegal).
- Main decode and the ID/EX register stay in id_ex_ctrl_stage.

Test Plan:
- Reset then ValidD=1, InstrD=0x002081B3 (add x3,x1,x2) -> after 1 edge: ALUControlE=0, RegWriteE=1, ALUSrcE=0, Rs1E=1, Rs2E=2, RdE=3, ValidE=1.
- InstrD=0x402081B3 (sub) -> ALUControlE=1. InstrD=0xFFF00293 (addi x5,x0,-1) -> ALUControlE=0, ALUSrcE=1, RdE=5.
- InstrD=0x00208463 (beq) -> ALUControlE=1, BranchE=1, ImmSrcE=10, RegWriteE=0. InstrD=0x0000A183 (lw) -> ResultSrcE=01, ALUSrcE=1.
- Load the add, then StallE=1 for 3 cycles while InstrD changes to sub -> outputs hold the add. Then StallE=1 with FlushE=1 -> bubble (ValidE=0, ALUControlE=0).
- InstrD=0x00000000, ValidD=1, ILLEGAL_TRAP=1 -> IllegalE=1, ValidE=1, RegWriteE=0, MemWriteE=0. Same stimulus with ILLEGAL_TRAP=0 -> ValidE=0, IllegalE=0.
- Drop rst_n low between edges while the sub is held -> all outputs 0 immediately, without waiting for clk. Release rst_n -> the next edge loads the current InstrD normally.
